// File: rtl/vote_pkg.sv
// Shared types and constants for the 5-voter majority session controller.
package vote_pkg;

    typedef enum logic [1:0] {IDLE, COLLECT, RESOLVE} state_t;

    localparam int N_VOTERS   = 5;
    localparam int MAJ_THRESH = 3;

endpackage

// File: rtl/maj5_vote.sv
// Combinational 5-input majority with population count of the set inputs.
module maj5_vote
    import vote_pkg::*;
(
    input  logic [N_VOTERS-1:0] votes,
    output logic                maj,
    output logic [2:0]          cnt
);

    always_comb begin
        cnt = 3'd0;
        for (int i = 0; i < N_VOTERS; i++) begin
            cnt = cnt + 3'(votes[i]);
        end
        maj = (cnt >= 3'(MAJ_THRESH));
    end

endmodule

// File: rtl/vote_session_ctrl.sv
// One 5-voter ballot: open on start, collect one vote per voter, resolve on majority/all/timeout.
// Define VOTE_EARLY_EXIT_EN to close the session as soon as a 3-vote majority exists.
module vote_session_ctrl
    import vote_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TMR_W          = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [N_VOTERS-1:0] vote_valid,
    input  logic [N_VOTERS-1:0] vote_val,
    output logic [N_VOTERS-1:0] vote_ack,
    output logic                busy,
    output logic [N_VOTERS-1:0] cast_mask,
    output logic                done,
    output logic                result,
    output logic                timed_out
);

    localparam logic [TMR_W-1:0] TmrLast = TMR_W'(TIMEOUT_CYCLES - 1);

    state_t              state;
    logic [N_VOTERS-1:0] votes;
    logic [TMR_W-1:0]    timer;

    logic [N_VOTERS-1:0] yes_vec, no_vec, accept;
    logic [2:0]          yes_cnt, no_cnt;
    logic                yes_maj, no_maj;
    logic                decided, all_cast, timeout, exit_now;

    assign yes_vec = cast_mask & votes;
    assign no_vec  = cast_mask & ~votes;
    assign accept  = vote_valid & ~cast_mask;

    maj5_vote u_yes (.votes(yes_vec), .maj(yes_maj), .cnt(yes_cnt));
    maj5_vote u_no  (.votes(no_vec),  .maj(no_maj),  .cnt(no_cnt));

    // Every voter is cast exactly when the yes and no tallies cover all five.
    assign all_cast = ({1'b0, yes_cnt} + {1'b0, no_cnt}) == 4'(N_VOTERS);
    assign decided  = yes_maj | no_maj;
    assign timeout  = (timer == TmrLast);

`ifdef VOTE_EARLY_EXIT_EN
    assign exit_now = decided | all_cast | timeout;
`else
    assign exit_now = all_cast | timeout;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            vote_ack  <= '0;
            cast_mask <= '0;
            votes     <= '0;
            timer     <= '0;
            done      <= 1'b0;
            result    <= 1'b0;
            timed_out <= 1'b0;
        end else begin
            vote_ack <= '0;
            done     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        cast_mask <= '0;
                        votes     <= '0;
                        timer     <= '0;
                        busy      <= 1'b1;
                        state     <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (exit_now) begin
                        done      <= 1'b1;
                        result    <= yes_maj;
                        timed_out <= ~decided;
                        state     <= RESOLVE;
                    end else begin
                        cast_mask <= cast_mask | accept;
                        votes     <= (votes & ~accept) | (vote_val & accept);
                        vote_ack  <= accept;
                        timer     <= timer + TMR_W'(1);
                    end
                end
                RESOLVE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
